// File: rtl/mandel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandel_pkg                                                      |
// | Purpose  : Shared fixed-point parameters, types and constants for the      |
// |            Mandelbrot escape-time engine.                                  |
// | Contents : W/FRAC_W/MAX_ITER/CNT_W/TAG_W defaults, fix_t, state_t,         |
// |            FIX_FOUR, FIX_LIMIT_C and the to_fix() real conversion helper.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mandel_pkg;

   localparam int W        = 32;     // total signed fixed-point width
   localparam int FRAC_W   = 28;     // fractional bits (Q4.28 by default)
   localparam int MAX_ITER = 1000;   // iteration limit
   localparam int CNT_W    = 10;     // count width, 2**CNT_W > MAX_ITER
   localparam int TAG_W    = 16;     // pixel coordinate tag width

   typedef logic signed [W-1:0] fix_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // 4.0 in fixed point: escape radius squared.
   localparam fix_t FIX_FOUR    = fix_t'(4) <<< FRAC_W;
   // |c| component limit above which the point is rejected without iterating.
   localparam fix_t FIX_LIMIT_C = fix_t'(4) <<< FRAC_W;

   // Real to fixed-point conversion (rounding); stimulus helper only.
   function automatic fix_t to_fix(input real r);
      longint v;
      v = longint'(r * (2.0 ** FRAC_W));
      return fix_t'(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mandel_iter_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandel_iter_engine_if                                           |
// | Purpose  : Input-point and result handshake bundle of the escape engine.   |
// | Ports    : in_valid/in_ready/in_c_re/in_c_im/in_x/in_y  (point in)          |
// |            out_valid/out_ready/out_n/out_x/out_y        (result out)        |
// |            master = point producer / result consumer, slave = engine.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mandel_iter_engine_if #(
   parameter int W     = mandel_pkg::W,
   parameter int TAG_W = mandel_pkg::TAG_W,
   parameter int CNT_W = mandel_pkg::CNT_W
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_c_re;
   logic signed [W-1:0] in_c_im;
   logic [TAG_W-1:0]    in_x;
   logic [TAG_W-1:0]    in_y;
   logic                out_valid;
   logic                out_ready;
   logic [CNT_W-1:0]    out_n;
   logic [TAG_W-1:0]    out_x;
   logic [TAG_W-1:0]    out_y;

   modport master (
      output in_valid, in_c_re, in_c_im, in_x, in_y, out_ready,
      input  in_ready, out_valid, out_n, out_x, out_y
   );

   modport slave (
      input  in_valid, in_c_re, in_c_im, in_x, in_y, out_ready,
      output in_ready, out_valid, out_n, out_x, out_y
   );
endinterface
`default_nettype wire

// File: rtl/mandel_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandel_step                                                     |
// | Purpose  : One combinational z <= z^2 + c step with escape test.           |
// | Ports    : re, im       current z (signed fixed point)                     |
// |            c_re, c_im   point c                                            |
// |            escape       re^2 + im^2 > 4.0                                  |
// |            next_re/im   z^2 + c, meaningful only when escape is low        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mandel_step #(
   parameter int W      = mandel_pkg::W,
   parameter int FRAC_W = mandel_pkg::FRAC_W
) (
   input  logic signed [W-1:0] re,
   input  logic signed [W-1:0] im,
   input  logic signed [W-1:0] c_re,
   input  logic signed [W-1:0] c_im,
   output logic                escape,
   output logic signed [W-1:0] next_re,
   output logic signed [W-1:0] next_im
);
   import mandel_pkg::*;

   localparam int PW = 2 * W;
   localparam logic signed [PW:0] FOUR_WIDE = (PW + 1)'(4) <<< FRAC_W;

   logic signed [PW-1:0] w_re_x;
   logic signed [PW-1:0] w_im_x;
   logic signed [PW-1:0] w_re_sq;
   logic signed [PW-1:0] w_im_sq;
   logic signed [PW-1:0] w_re_im;
   logic signed [PW-1:0] w_x_sq;
   logic signed [PW-1:0] w_y_sq;
   logic signed [PW-1:0] w_xy2;
   logic signed [PW:0]   w_mag;

   assign w_re_x  = {{W{re[W-1]}}, re};
   assign w_im_x  = {{W{im[W-1]}}, im};
   assign w_re_sq = w_re_x * w_re_x;
   assign w_im_sq = w_im_x * w_im_x;
   assign w_re_im = w_re_x * w_im_x;

   // Squares stay at full product width: |re| can approach 8 on the escaping
   // index, so re^2 does not fit in W bits and the compare must not wrap.
   assign w_x_sq = w_re_sq >>> FRAC_W;
   assign w_y_sq = w_im_sq >>> FRAC_W;
   // Shifting one bit less than FRAC_W yields 2*re*im directly.
   assign w_xy2  = w_re_im >>> (FRAC_W - 1);

   assign w_mag  = {w_x_sq[PW-1], w_x_sq} + {w_y_sq[PW-1], w_y_sq};
   assign escape = (w_mag > FOUR_WIDE);

   // Without escape both squares are <= 4.0, so their W-bit truncations are exact.
   assign next_re = W'(w_x_sq) - W'(w_y_sq) + c_re;
   assign next_im = W'(w_xy2) + c_im;

endmodule
`default_nettype wire

// File: rtl/mandel_iter_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandel_iter_engine                                              |
// | Purpose  : Fixed-point Mandelbrot escape-time engine, one iteration per    |
// |            clock, one point in flight, valid/ready on both sides.          |
// | Ports    : sync_clk  rising-edge clock                                     |
// |            rst_n     synchronous active-low reset                          |
// |            bus       mandel_iter_engine_if.slave (point in, result out)    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mandel_iter_engine #(
   parameter int W        = mandel_pkg::W,
   parameter int FRAC_W   = mandel_pkg::FRAC_W,
   parameter int MAX_ITER = mandel_pkg::MAX_ITER,
   parameter int CNT_W    = mandel_pkg::CNT_W,
   parameter int TAG_W    = mandel_pkg::TAG_W
) (
   input  logic                 sync_clk,
   input  logic                 rst_n,
   mandel_iter_engine_if.slave  bus
);
   import mandel_pkg::*;

   localparam logic signed [W-1:0] LIMIT_C   = W'(4) <<< FRAC_W;
   localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(MAX_ITER - 1);

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [CNT_W-1:0]    r_out_n;
   logic [TAG_W-1:0]    r_out_x;
   logic [TAG_W-1:0]    r_out_y;
   logic signed [W-1:0] r_re;
   logic signed [W-1:0] r_im;
   logic signed [W-1:0] r_c_re;
   logic signed [W-1:0] r_c_im;
   logic [CNT_W-1:0]    r_iter;

   logic                w_escape;
   logic signed [W-1:0] w_next_re;
   logic signed [W-1:0] w_next_im;
   logic                w_fast;

   mandel_step #(
      .W      (W),
      .FRAC_W (FRAC_W)
   ) u_step (
      .re      (r_re),
      .im      (r_im),
      .c_re    (r_c_re),
      .c_im    (r_c_im),
      .escape  (w_escape),
      .next_re (w_next_re),
      .next_im (w_next_im)
   );

   // Points with a component of magnitude >= 4 escape immediately; rejecting
   // them here also keeps every iterated value inside the W-bit range.
   assign w_fast = (bus.in_c_re >= LIMIT_C) || (bus.in_c_re <= -LIMIT_C) ||
                   (bus.in_c_im >= LIMIT_C) || (bus.in_c_im <= -LIMIT_C);

   always_ff @(posedge sync_clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_n     <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_re        <= '0;
         r_im        <= '0;
         r_c_re      <= '0;
         r_c_im      <= '0;
         r_iter      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_c_re     <= bus.in_c_re;
                  r_c_im     <= bus.in_c_im;
                  r_out_x    <= bus.in_x;
                  r_out_y    <= bus.in_y;
                  r_re       <= '0;
                  r_im       <= '0;
                  r_iter     <= '0;
                  r_in_ready <= 1'b0;
                  if (w_fast) begin
                     r_out_n     <= CNT_W'(1);
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_state     <= ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               if (w_escape) begin
                  r_out_n     <= r_iter;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_re   <= w_next_re;
                  r_im   <= w_next_im;
                  r_iter <= r_iter + CNT_W'(1);
                  if (r_iter == LAST_ITER) begin
                     // Iteration budget exhausted: report "never escaped".
                     r_out_n     <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Result registers are only written in IDLE/ITER, so they
               // hold steady here until the consumer takes them.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_n     = r_out_n;
   assign bus.out_x     = r_out_x;
   assign bus.out_y     = r_out_y;

endmodule
`default_nettype wire

// File: tb/tb_mandel_iter_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mandel_iter_engine                                           |
// | Purpose  : Directed self-checking bench for mandel_iter_engine.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mandel_iter_engine;
   import mandel_pkg::*;

   localparam int LAT_BOUND = MAX_ITER + 100;

   logic sync_clk;
   logic rst_n;
   int   total;
   int   bad;
   bit   busy_ok;

   mandel_iter_engine_if #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   mandel_iter_engine #(
      .W        (W),
      .FRAC_W   (FRAC_W),
      .MAX_ITER (MAX_ITER),
      .CNT_W    (CNT_W),
      .TAG_W    (TAG_W)
   ) dut (
      .sync_clk (sync_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial sync_clk = 1'b0;
   always #5 sync_clk = ~sync_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Offers one point, then counts edges after the accepting edge until
   // out_valid is seen (0 means valid straight after the accept edge).
   task automatic run_point(input fix_t cr, input fix_t ci,
                            input logic [TAG_W-1:0] x, input logic [TAG_W-1:0] y,
                            output int lat);
      @(negedge sync_clk);
      chk("ready_before_accept", bus.in_ready, 1);
      bus.in_c_re  = cr;
      bus.in_c_im  = ci;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_valid = 1'b1;
      @(posedge sync_clk);
      #1;
      bus.in_valid = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < LAT_BOUND) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(posedge sync_clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge sync_clk);
      bus.out_ready = 1'b1;
      @(posedge sync_clk);
      #1;
      bus.out_ready = 1'b0;
      chk("release_valid", bus.out_valid, 0);
      chk("release_ready", bus.in_ready, 1);
   endtask

   task automatic point_case(input string tag, input real cr, input real ci,
                             input int x, input int y, input int exp_n, input int exp_lat);
      int lat;
      run_point(to_fix(cr), to_fix(ci), TAG_W'(x), TAG_W'(y), lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_n"}, bus.out_n, exp_n);
      chk({tag, "_x"}, bus.out_x, x);
      chk({tag, "_y"}, bus.out_y, y);
      chk({tag, "_busy"}, busy_ok, 1);
      take_result();
   endtask

   initial begin
      bit stable;
      total = 0;
      bad   = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_c_re   = '0;
      bus.in_c_im   = '0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge sync_clk);
      @(negedge sync_clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_n_out", bus.out_n, 0);
      chk("rst_x", bus.out_x, 0);
      chk("rst_y", bus.out_y, 0);
      rst_n = 1'b1;

      // z: 0 -> 1 -> 2 -> 5, escape seen at index 3
      point_case("c1", 1.0, 0.0, 5, 7, 3, 4);
      // z: 0 -> 2.5, escape seen at index 1
      point_case("c25", 2.5, 0.0, 10, 11, 1, 2);
      // z: 0, .5+.5i, .5+1i, -.25+1.5i, -1.6875-.25i, 3.28515625+1.34375i -> index 5
      point_case("chalf", 0.5, 0.5, 100, 200, 5, 6);
      // fast path: result visible right after the accepting edge
      point_case("fast5", 5.0, 0.0, 1, 2, 1, 0);
      point_case("fast_im_m4", 0.0, -4.0, 3, 3, 1, 0);
      // exact fixed points never escape
      point_case("c0", 0.0, 0.0, 40, 41, 0, MAX_ITER);
      point_case("cm2", -2.0, 0.0, 42, 43, 0, MAX_ITER);

      // Backpressure with a competing point offered during the stall.
      begin
         int lat;
         run_point(to_fix(2.5), to_fix(0.0), 16'd3, 16'd4, lat);
         chk("bp_lat", lat, 2);
         @(negedge sync_clk);
         bus.in_c_re  = to_fix(5.0);
         bus.in_c_im  = to_fix(0.0);
         bus.in_x     = 16'd9;
         bus.in_y     = 16'd8;
         bus.in_valid = 1'b1;
         stable = 1'b1;
         for (int k = 0; k < 10; k++) begin
            @(posedge sync_clk);
            #1;
            if (!bus.out_valid || bus.out_n != CNT_W'(1) ||
                bus.out_x != 16'd3 || bus.out_y != 16'd4 || bus.in_ready)
               stable = 1'b0;
         end
         chk("bp_stable", stable, 1);
         @(negedge sync_clk);
         bus.out_ready = 1'b1;
         @(posedge sync_clk);
         #1;
         bus.out_ready = 1'b0;
         chk("bp_bubble_valid", bus.out_valid, 0);
         chk("bp_bubble_ready", bus.in_ready, 1);
         @(posedge sync_clk);
         #1;
         bus.in_valid = 1'b0;
         chk("bp_next_valid", bus.out_valid, 1);
         chk("bp_next_n", bus.out_n, 1);
         chk("bp_next_x", bus.out_x, 9);
         chk("bp_next_y", bus.out_y, 8);
         take_result();
      end

      // Reset while iterating abandons the point.
      @(negedge sync_clk);
      bus.in_c_re  = to_fix(0.0);
      bus.in_c_im  = to_fix(0.0);
      bus.in_x     = 16'd77;
      bus.in_y     = 16'd78;
      bus.in_valid = 1'b1;
      @(posedge sync_clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (49) @(posedge sync_clk);
      @(negedge sync_clk);
      chk("mid_busy", bus.in_ready, 0);
      rst_n = 1'b0;
      @(posedge sync_clk);
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_ready", bus.in_ready, 1);
      chk("mid_rst_n", bus.out_n, 0);
      @(negedge sync_clk);
      rst_n = 1'b1;
      point_case("after_rst", 1.0, 0.0, 21, 22, 3, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
